instruction_loader: RTL and testbench

//  Write-side counterpart of the instruction fetch/decode stage. Accepts decoded fields
//  (opcode, rDest, rSrc / jump target), packs them into 8-bit instruction words
//  {opcode[1:0], rDest[2:0], rSrc[2:0]} and writes them sequentially into the instruction

---
 rtl/instruction_loader_pkg.sv | 32 +++
 rtl/loader_fifo.sv | 48 ++++
 rtl/instruction_loader.sv | 143 ++++++++++++++
 tb/tb_instruction_loader.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_loader_pkg.sv
// Shared definitions for the instruction loader: instruction field layout, opcodes, FSM states.
package instruction_loader_pkg;

   localparam int unsigned INSTR_W   = 8;
   localparam int unsigned OP_W      = 2;
   localparam int unsigned REG_W     = 3;
   localparam int unsigned JMP_TGT_W = 6;
   localparam int unsigned PAGE_MSB  = 7;
   localparam int unsigned PAGE_LSB  = 6;

   localparam logic [OP_W-1:0] OP_JMP = 2'b11;

   typedef enum logic [1:0] {
      StIdle,
      StLoad,
      StDone
   } state_e;

   // Jumps keep only the in-page target; fetch restores the page bits from the pc.
   function automatic logic [INSTR_W-1:0] pack_instr(
      input logic [OP_W-1:0]      op,
      input logic [REG_W-1:0]     rdest,
      input logic [REG_W-1:0]     rsrc,
      input logic [JMP_TGT_W-1:0] tgt
   );
      if (op == OP_JMP) begin
         return {OP_JMP, tgt};
      end
      return {op, rdest, rsrc};
   endfunction

endpackage

// File: rtl/loader_fifo.sv
// Small synchronous FIFO buffering packed instruction words between accept and memory write.
module loader_fifo #(
   parameter int unsigned Width = 8,
   parameter int unsigned Depth = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic                       pop,
   input  logic [Width-1:0]           wdata,
   output logic [Width-1:0]           rdata,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(Depth):0]     count
);
   localparam int unsigned PtrW = $clog2(Depth);
   localparam int unsigned CntW = PtrW + 1;

   logic [Width-1:0] mem_q [Depth];
   logic [PtrW-1:0]  wptr_q, rptr_q;
   logic [CntW-1:0]  count_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (push) wptr_q <= wptr_q + PtrW'(1);
         if (pop)  rptr_q <= rptr_q + PtrW'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + CntW'(1);
            2'b01:   count_q <= count_q - CntW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wptr_q] <= wdata;
   end

   assign rdata = mem_q[rptr_q];
   assign full  = (count_q == CntW'(Depth));
   assign empty = (count_q == '0);
   assign count = count_q;

endmodule

// File: rtl/instruction_loader.sv
// Packs decoded instruction fields into 8-bit words and streams them into the instruction file.
module instruction_loader
   import instruction_loader_pkg::*;
#(
   parameter int unsigned ADDR_W     = 8,
   parameter int unsigned MEM_DEPTH  = 8,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W-1:0] length,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [1:0]        in_opcode,
   input  logic [2:0]        in_rDest,
   input  logic [2:0]        in_rSrc,
   input  logic [ADDR_W-1:0] in_jump_addr,
   input  logic              mem_busy,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [7:0]        wr_data,
   output logic              busy,
   output logic              done,
   output logic              range_err,
   output logic              page_err
);
   localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   base_q, base_d, len_q, len_d;
   logic [ADDR_W-1:0]   acc_q, acc_d, wr_cnt_q, wr_cnt_d;
   logic                range_err_q, range_err_d, page_err_q, page_err_d;

   logic                push, pop, fifo_full, fifo_empty;
   logic [INSTR_W-1:0]  packed_word, fifo_head;
   logic [CntW-1:0]     fifo_count;
   logic [ADDR_W-1:0]   acc_addr;
   logic                range_bad;

   assign packed_word = pack_instr(in_opcode, in_rDest, in_rSrc, in_jump_addr[JMP_TGT_W-1:0]);
   // One extra bit so base+length cannot wrap before the comparison.
   assign range_bad   = ({1'b0, base_addr} + {1'b0, length}) > (ADDR_W+1)'(MEM_DEPTH);
   assign acc_addr    = base_q + acc_q;

   always_comb begin
      state_d     = state_q;
      base_d      = base_q;
      len_d       = len_q;
      acc_d       = acc_q;
      wr_cnt_d    = wr_cnt_q;
      range_err_d = range_err_q;
      page_err_d  = page_err_q;
      in_ready    = 1'b0;
      push        = 1'b0;
      pop         = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               if (range_bad) begin
                  range_err_d = 1'b1;
               end else begin
                  base_d      = base_addr;
                  len_d       = length;
                  acc_d       = '0;
                  wr_cnt_d    = '0;
                  range_err_d = 1'b0;
                  page_err_d  = 1'b0;
                  state_d     = (length == '0) ? StDone : StLoad;
               end
            end
         end
         StLoad: begin
            in_ready = !fifo_full && (acc_q < len_q);
            push     = in_valid && in_ready;
            pop      = !fifo_empty && !mem_busy;
            if (push) begin
               acc_d = acc_q + ADDR_W'(1);
               // Words are written in accept order, so this tuple lands at base+accepted.
               if (in_opcode == OP_JMP &&
                   in_jump_addr[PAGE_MSB:PAGE_LSB] != acc_addr[PAGE_MSB:PAGE_LSB]) begin
                  page_err_d = 1'b1;
               end
            end
            if (pop) begin
               wr_cnt_d = wr_cnt_q + ADDR_W'(1);
               if (wr_cnt_q + ADDR_W'(1) == len_q) state_d = StDone;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= StIdle;
         base_q      <= '0;
         len_q       <= '0;
         acc_q       <= '0;
         wr_cnt_q    <= '0;
         range_err_q <= 1'b0;
         page_err_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         base_q      <= base_d;
         len_q       <= len_d;
         acc_q       <= acc_d;
         wr_cnt_q    <= wr_cnt_d;
         range_err_q <= range_err_d;
         page_err_q  <= page_err_d;
      end
   end

   loader_fifo #(
      .Width (INSTR_W),
      .Depth (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .wdata (packed_word),
      .rdata (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign wr_en     = pop;
   assign wr_addr   = pop ? base_q + wr_cnt_q : '0;
   assign wr_data   = pop ? fifo_head : '0;
   assign busy      = (state_q == StLoad);
   assign done      = (state_q == StDone);
   assign range_err = range_err_q;
   assign page_err  = page_err_q;

   // Buffered words are exactly those accepted but not yet written.
   a_fifo_occupancy: assert property (@(posedge clk) disable iff (!reset)
      ADDR_W'(fifo_count) == acc_q - wr_cnt_q);

endmodule

// File: tb/tb_instruction_loader.sv
// Randomised bench for instruction_loader checked against a queue-based session model.
module tb_instruction_loader;
   localparam int unsigned ADDR_W     = 8;
   localparam int unsigned MEM_DEPTH  = 8;
   localparam int unsigned FIFO_DEPTH = 4;

   typedef struct packed {
      logic [1:0] op;
      logic [2:0] rd;
      logic [2:0] rs;
      logic [7:0] ja;
   } tuple_t;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              start = 1'b0;
   logic [ADDR_W-1:0] base_addr = '0;
   logic [ADDR_W-1:0] length = '0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [1:0]        in_opcode = '0;
   logic [2:0]        in_rDest = '0;
   logic [2:0]        in_rSrc = '0;
   logic [ADDR_W-1:0] in_jump_addr = '0;
   logic              mem_busy = 1'b0;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [7:0]        wr_data;
   logic              busy, done, range_err, page_err;

   int     n_checks = 0;
   int     n_fail = 0;
   int     busy_pct = 0;
   int     busy_hold = 0;
   int     gap_pct = 0;
   int     drop_idx = -1;
   bit     model_rerr = 1'b0;
   bit     model_perr = 1'b0;
   tuple_t stim_q[$];
   logic [15:0] wr_log[$];

   instruction_loader #(
      .ADDR_W     (ADDR_W),
      .MEM_DEPTH  (MEM_DEPTH),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .base_addr    (base_addr),
      .length       (length),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_opcode    (in_opcode),
      .in_rDest     (in_rDest),
      .in_rSrc      (in_rSrc),
      .in_jump_addr (in_jump_addr),
      .mem_busy     (mem_busy),
      .wr_en        (wr_en),
      .wr_addr      (wr_addr),
      .wr_data      (wr_data),
      .busy         (busy),
      .done         (done),
      .range_err    (range_err),
      .page_err     (page_err)
   );

   always #5 clk = ~clk;

   initial begin
      forever begin
         @(posedge clk);
         #2;
         if (busy_hold > 0) begin
            mem_busy  = 1'b1;
            busy_hold = busy_hold - 1;
         end else begin
            mem_busy = (int'($urandom_range(99)) < busy_pct);
         end
      end
   end

   always @(negedge clk) begin
      if (wr_en) wr_log.push_back({wr_addr, wr_data});
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] model_pack(input tuple_t t);
      if (t.op == 2'b11) return 8'(192 + int'(t.ja) % 64);
      return 8'(int'(t.op) * 64 + int'(t.rd) * 8 + int'(t.rs));
   endfunction

   task automatic drive_garbage();
      {in_opcode, in_rDest, in_rSrc, in_jump_addr} = 16'($urandom);
   endtask

   task automatic fill_random(input int n);
      tuple_t t;
      stim_q.delete();
      for (int i = 0; i < n; i++) begin
         t = tuple_t'(16'($urandom));
         stim_q.push_back(t);
      end
   endtask

   // Entered and left at posedge+1. abort_after >= 0 pulls reset once that many writes are seen.
   task automatic run_session(input logic [7:0] base, input logic [7:0] len,
                              input int abort_after, input string tag);
      logic [15:0] exp_q[$];
      logic [7:0]  a;
      bit          rerr;
      bit          saw_done;
      int          idx;
      int          cyc;
      int          n;
      rerr = (int'(base) + int'(len)) > int'(MEM_DEPTH);
      if (rerr) begin
         model_rerr = 1'b1;
      end else begin
         model_rerr = 1'b0;
         model_perr = 1'b0;
         for (int i = 0; i < int'(len); i++) begin
            a = base + 8'(i);
            exp_q.push_back({a, model_pack(stim_q[i])});
            if (stim_q[i].op == 2'b11 && (int'(stim_q[i].ja) / 64) != (int'(a) / 64))
               model_perr = 1'b1;
         end
      end
      wr_log.delete();
      drop_idx = -1;
      base_addr = base;
      length    = len;
      start     = 1'b1;
      in_valid  = 1'b1;
      drive_garbage();
      @(posedge clk);
      #1;
      start    = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      check({tag, " busy after start"}, 32'(busy), 32'(!rerr && len != 0));
      check({tag, " done after start"}, 32'(done), 32'(!rerr && len == 0));
      check({tag, " range_err after start"}, 32'(range_err), 32'(model_rerr));
      saw_done = done;
      @(posedge clk);
      #1;
      idx = 0;
      cyc = 0;
      if (!rerr) begin
         while (!saw_done && cyc < 500) begin
            if (abort_after >= 0 && wr_log.size() >= abort_after) break;
            if (idx < int'(len) && int'($urandom_range(99)) >= gap_pct) begin
               in_valid = 1'b1;
               {in_opcode, in_rDest, in_rSrc, in_jump_addr} = stim_q[idx];
            end else begin
               in_valid = 1'b0;
               drive_garbage();
            end
            @(negedge clk);
            if (drop_idx < 0 && busy && in_valid && !in_ready) drop_idx = idx;
            if (in_valid && in_ready) idx++;
            if (done) saw_done = 1'b1;
            @(posedge clk);
            #1;
            cyc++;
         end
      end else begin
         repeat (4) begin
            in_valid = 1'b1;
            drive_garbage();
            @(posedge clk);
            #1;
         end
      end
      in_valid = 1'b0;

      if (abort_after >= 0) begin
         check({tag, " writes before abort"}, 32'(wr_log.size() >= abort_after), 32'd1);
         reset = 1'b0;
         @(negedge clk);
         check({tag, " outputs in reset"},
               32'({wr_en, busy, done, in_ready, range_err, page_err, wr_addr, wr_data}), 32'd0);
         n = abort_after;
         model_rerr = 1'b0;
         model_perr = 1'b0;
      end else begin
         if (!rerr) check({tag, " done seen"}, 32'(saw_done), 32'd1);
         @(negedge clk);
         check({tag, " done one cycle"}, 32'(done), 32'd0);
         check({tag, " idle busy"}, 32'(busy), 32'd0);
         n = exp_q.size();
      end
      check({tag, " write count"}, 32'(wr_log.size()), 32'(n));
      for (int i = 0; i < n && i < wr_log.size(); i++)
         check($sformatf("%s write %0d", tag, i), 32'(wr_log[i]), 32'(exp_q[i]));
      check({tag, " range_err"}, 32'(range_err), 32'(model_rerr));
      check({tag, " page_err"}, 32'(page_err), 32'(model_perr));
      @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset outputs",
            32'({wr_en, busy, done, in_ready, range_err, page_err, wr_addr, wr_data}), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;

      stim_q.delete();
      stim_q.push_back(tuple_t'{2'b00, 3'b001, 3'b000, 8'h00});
      stim_q.push_back(tuple_t'{2'b01, 3'b001, 3'b011, 8'h00});
      stim_q.push_back(tuple_t'{2'b01, 3'b000, 3'b010, 8'h00});
      run_session(8'd0, 8'd3, -1, "basic3");
      if (wr_log.size() == 3) check("basic3 word1 literal", 32'(wr_log[1]), 32'h014B);

      stim_q.delete();
      stim_q.push_back(tuple_t'{2'b11, 3'b000, 3'b000, 8'h05});
      run_session(8'd4, 8'd1, -1, "jump_same_page");
      if (wr_log.size() == 1) check("jump literal", 32'(wr_log[0]), 32'h04C5);

      stim_q.delete();
      stim_q.push_back(tuple_t'{2'b11, 3'b000, 3'b000, 8'h45});
      run_session(8'd0, 8'd1, -1, "jump_cross_page");

      run_session(8'd6, 8'd3, -1, "range_bad");

      reset = 1'b0;
      @(negedge clk);
      check("reset clears sticky", 32'({range_err, page_err}), 32'd0);
      model_rerr = 1'b0;
      model_perr = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;

      fill_random(6);
      busy_hold = 6;
      run_session(8'd0, 8'd6, -1, "busy_backpressure");
      check("ready drops after fifo fills", 32'(drop_idx), 32'd4);

      run_session(8'd3, 8'd0, -1, "empty_session");

      fill_random(6);
      run_session(8'd1, 8'd6, 2, "abort");
      @(posedge clk);
      #1;
      fill_random(4);
      run_session(8'd2, 8'd4, -1, "after_abort");

      for (int s = 0; s < 25; s++) begin
         logic [7:0] b, l;
         busy_pct = int'($urandom_range(50));
         gap_pct  = int'($urandom_range(50));
         b = 8'($urandom_range(7));
         if ($urandom_range(9) < 8) l = 8'($urandom_range(8 - int'(b)));
         else l = 8'(9 - int'(b) + int'($urandom_range(3)));
         fill_random(int'(l));
         run_session(b, l, -1, $sformatf("rand%0d", s));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
